// File: rtl/async_receiver.sv
// Serial frame receiver: start, DATA_BITS data (LSB first), odd parity, stop; one line bit per Clk.
// Latency: word visible after edge k+DATA_BITS+2, where k is the edge that samples the start bit.
// Backpressure: one-entry holding register with Valid/Ready; a frame completing while full is dropped and flags Overrun.
module async_receiver #(
    parameter int   DATA_BITS  = 5,
    parameter logic STOP_LEVEL = 1'b0
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    input  logic                 D,
    input  logic                 Ready,
    output logic [DATA_BITS-1:0] Dout,
    output logic                 Valid,
    output logic                 ParityErr,
    output logic                 FrameErr,
    output logic                 Overrun
);

    localparam int CW = $clog2(DATA_BITS) + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   acc_q, acc_d;
    logic                   perr_q, perr_d;

    logic [DATA_BITS-1:0]   dout_q, dout_d;
    logic                   valid_q, valid_d;
    logic                   perr_out_q, perr_out_d;
    logic                   ferr_out_q, ferr_out_d;
    logic                   ovr_q, ovr_d;

    logic                   complete;
    logic                   ferr_next;
    logic                   accept;

    // Frame FSM: next state, payload capture and parity/stop evaluation.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        perr_d    = perr_q;
        complete  = 1'b0;
        ferr_next = 1'b0;
        case (state_q)
            IDLE: begin
                // No start-edge hunting: any 0 seen while idle begins a frame.
                if (!D) begin
                    state_d = DATA;
                    cnt_d   = '0;
                    acc_d   = 1'b0;
                end
            end
            DATA: begin
                for (int i = 0; i < DATA_BITS; i++) begin
                    if (cnt_q == CW'(i)) begin
                        shift_d[i] = D;
                    end
                end
                acc_d = acc_q ^ D;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(DATA_BITS - 1)) begin
                    state_d = PARITY;
                end
            end
            PARITY: begin
                // Odd parity: data plus parity bit must hold an odd number of ones.
                perr_d  = ~(acc_q ^ D);
                state_d = STOP;
            end
            STOP: begin
                ferr_next = (D != STOP_LEVEL);
                complete  = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Holding register: load on completion if empty or being drained, else drop and flag overrun.
    always_comb begin
        dout_d     = dout_q;
        valid_d    = valid_q;
        perr_out_d = perr_out_q;
        ferr_out_d = ferr_out_q;
        ovr_d      = ovr_q;
        accept     = valid_q & Ready;
        if (accept) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end
        if (complete) begin
            if (!valid_q || Ready) begin
                dout_d     = shift_d;
                perr_out_d = perr_q;
                ferr_out_d = ferr_next;
                valid_d    = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    // Frame FSM state and datapath registers.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            acc_q   <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            perr_q  <= perr_d;
        end
    end

    // Holding register and sticky overrun flag.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            dout_q     <= '0;
            valid_q    <= 1'b0;
            perr_out_q <= 1'b0;
            ferr_out_q <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            dout_q     <= dout_d;
            valid_q    <= valid_d;
            perr_out_q <= perr_out_d;
            ferr_out_q <= ferr_out_d;
            ovr_q      <= ovr_d;
        end
    end

    assign Dout      = dout_q;
    assign Valid     = valid_q;
    assign ParityErr = perr_out_q;
    assign FrameErr  = ferr_out_q;
    assign Overrun   = ovr_q;

endmodule

// File: doc/async_receiver.md
Name: async_receiver

Overview:
- Serial frame receiver that sits directly downstream of the async serial transmitter and consumes its single-wire output D.
- Samples one line bit per Clk rising edge and reassembles the payload. Checks odd parity and the stop-bit level.
- Presents each received word in a one-entry holding register with a Valid/Ready handshake, plus an overrun flag.

Parameters:
- DATA_BITS, 5, payload bits per frame, sent LSB first.
- STOP_LEVEL, 0, required line level of the stop bit.

Ports:
- Clk  input  1  system clock; all sampling on rising edge.
- Rst_n  input  1  asynchronous active-low reset.
- D  input  1  serial line, one bit per Clk, registered in the Clk domain upstream; idle level 1.
- Ready  input  1  consumer accepts the held word when Ready=1 and Valid=1 at a rising edge.
- Dout  output  DATA_BITS  received payload, Dout[0] = first data bit on the line.
- Valid  output  1  holding register contains an unconsumed word.
- ParityErr  output  1  parity status of the held word.
- FrameErr  output  1  stop-bit status of the held word.
- Overrun  output  1  at least one completed frame was dropped because the holding register was full.

Behaviour:
- Reset: already decided — one clock Clk; Rst_n is asynchronous and active-low.
  - While Rst_n=0: state IDLE; shift register, bit counter and parity accumulator = 0; Dout=0, Valid=0, ParityErr=0, FrameErr=0, Overrun=0.
  - Reset mid-frame aborts the frame and emits no Valid.
- Frame format, DATA_BITS+3 bits, one per cycle:
  - start bit (0);
  - DATA_BITS data bits, LSB first;
  - parity bit, odd: the count of 1s in data+parity must be odd;
  - stop bit (STOP_LEVEL).
- State machine, evaluated at each rising Clk edge:
  - IDLE: if D=0, go to DATA; clear the bit counter and parity accumulator. If D=1, stay in IDLE.
  - DATA: store D at shift[cnt], acc ^= D, cnt += 1. After DATA_BITS samples (cnt = DATA_BITS-1 sampled), go to PARITY.
  - PARITY: perr_next = ~(acc ^ D); go to STOP.
  - STOP: ferr_next = (D != STOP_LEVEL); frame complete; go to IDLE.
- Back-to-back frames:
  - With STOP_LEVEL=0, the next start bit may immediately follow the stop bit.
  - IDLE samples it on the very next edge; no gap cycle is required.
- A line held at 0 indefinitely is treated as repeated start bits, i.e. an all-zero data stream; the block does not hunt for a start edge.
- Latency: with the start bit sampled at edge k, frame completion occurs at edge k+DATA_BITS+2 (k+7 at defaults). Valid and data are visible after that edge.
- Holding register, at the completion edge:
  - If Valid=0, or Valid=1 and Ready=1 (simultaneous accept): load Dout=shift, ParityErr=perr_next, FrameErr=ferr_next, Valid=1. No overrun.
  - If Valid=1 and Ready=0: discard the new frame; Dout, ParityErr and FrameErr are unchanged; set Overrun=1.
- Handshake:
  - Valid=1 and Ready=1 at an edge with no completion: Valid becomes 0.
  - Dout and the error flags keep their last values after consumption; they are don't-care while Valid=0.
- Overrun is sticky; it clears only on an accepted handshake (Valid&Ready) or reset.
- Error frames are still delivered with Valid=1; the flags accompany the data and are never suppressed.
- Width rules:
  - cnt width is clog2(DATA_BITS)+1.
  - No arithmetic beyond the counter increment and the XOR accumulation.
  - Dout has exactly DATA_BITS bits.

Test Plan (DATA_BITS=5, STOP_LEVEL=0, bit order start,d0..d4,parity,stop):
- Clean frame: idle 1 for 3 cycles, then 0,1,0,1,0,1,0,0, Ready=0. Required: Valid rises after the 8th bit edge; Dout=5'h15, ParityErr=0, FrameErr=0. Valid stays 1 until Ready=1 for one edge, then drops to 0.
- Parity error: same frame with parity bit 1. Required: Dout=5'h15, ParityErr=1, FrameErr=0, Valid=1.
- Frame error: 0,1,1,1,1,1,0,1 (payload 5'h1F). Required: Dout=5'h1F, ParityErr=0, FrameErr=1.
- Back-to-back with Ready=1: 5'h15 frame, then immediately 0,0,1,0,1,0,1,0 (payload 5'h0A, parity 1). Required: Dout=5'h15, then Dout=5'h0A exactly 8 cycles later; both frames error-free; Overrun=0.
- Overrun: Ready=0; send 5'h15, then 5'h0A. Required: Dout remains 5'h15, Overrun=1, Valid=1. Then Ready=1 for one edge: Valid=0, Overrun=0.
- Reset mid-frame: Rst_n low after the 3rd data bit. Required: Valid=0, all outputs 0 immediately; no Valid afterwards. After release with line 1 for 2 cycles, frame 0,1,1,1,1,1,0,0 yields Dout=5'h1F with no errors.
